neuron_layer_array: RTL and testbench

//  Parametrised layer of NUM_NEURONS leaky integrate-and-fire neurons sharing one threshold and one control bus.

---
 rtl/neuron_layer_array.sv | 154 +++++++++++++++
 tb/tb_neuron_layer_array.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_array.sv
// neuron_layer_array
//   A layer of NUM_NEURONS leaky integrate-and-fire neurons. All neurons share
//   one threshold and one control bus. The layer provides indexed membrane
//   writes, hard or soft reset after a spike, a shift-based leak, per-neuron
//   refractory counters, per-neuron surrogate FIFOs and a saturating per-sample
//   spike counter.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   threshold_i                signed threshold shared by every neuron
//   membrane_update_i/_addr_i  membrane write data and target neuron
//   membrane_update_valid_i    write strobe
//   post_spiking_now_i         fire step for all neurons in parallel
//   training_state_i           capture membrane_past on a fire step
//   this_sample_done_i         last fire step of the sample; clears membranes
//   surrogate_compute_time_i   load surrogate_ref_i where membrane_past >= threshold
//   surrogate_ref_i            surrogate code to load
//   surrogate_read_finish_i    shift every surrogate FIFO by one stage
//   membrane_rd_addr_i         membrane readout select
//   membrane_o                 membrane of the selected neuron (combinational)
//   post_spike_o               registered spike vector, bit n = neuron n
//   surrogate_o                FIFO tail per neuron, neuron n at [n*W +: W]
//   spike_count_o              saturating count of spikes in the current sample
//
// Handshake: membrane_update_valid_i is a single-cycle strobe with no
// backpressure. The write is accepted on any clock edge where valid is high,
// post_spiking_now_i is low and the address names an existing neuron. A write
// that coincides with a fire step is dropped, not deferred.
module neuron_layer_array #(
  parameter int NUM_NEURONS         = 8,
  parameter int BIT_WIDTH_MEMBRANE  = 17,
  parameter int BIT_WIDTH_SURROGATE = 3,
  parameter int DEPTH_SURROGATE_BOX = 2,
  parameter int LEAK_SHIFT          = 1,
  parameter int RESET_MODE          = 0,
  parameter int REFRACTORY_STEPS    = 0,
  parameter int BIT_WIDTH_SPIKE_CNT = 8,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0]          threshold_i,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0]          membrane_update_i,
  input  logic [AW-1:0]                                 membrane_update_addr_i,
  input  logic                                          membrane_update_valid_i,
  input  logic                                          post_spiking_now_i,
  input  logic                                          training_state_i,
  input  logic                                          this_sample_done_i,
  input  logic                                          surrogate_compute_time_i,
  input  logic [BIT_WIDTH_SURROGATE-1:0]                surrogate_ref_i,
  input  logic                                          surrogate_read_finish_i,
  input  logic [AW-1:0]                                 membrane_rd_addr_i,
  output logic signed [BIT_WIDTH_MEMBRANE-1:0]          membrane_o,
  output logic [NUM_NEURONS-1:0]                        post_spike_o,
  output logic [NUM_NEURONS*BIT_WIDTH_SURROGATE-1:0]    surrogate_o,
  output logic [BIT_WIDTH_SPIKE_CNT-1:0]                spike_count_o
);

  localparam int MW = BIT_WIDTH_MEMBRANE;
  localparam int SW = BIT_WIDTH_SURROGATE;
  localparam int D  = DEPTH_SURROGATE_BOX;
  localparam int CW = BIT_WIDTH_SPIKE_CNT;
  localparam int RW = (REFRACTORY_STEPS > 0) ? $clog2(REFRACTORY_STEPS + 1) : 1;
  localparam int PW = $clog2(NUM_NEURONS + 1);
  localparam logic signed [MW-1:0] M_MAX = {1'b0, {(MW-1){1'b1}}};
  localparam logic signed [MW-1:0] M_MIN = {1'b1, {(MW-1){1'b0}}};

  logic signed [MW-1:0] membrane      [NUM_NEURONS];
  logic signed [MW-1:0] membrane_past [NUM_NEURONS];
  logic [RW-1:0]        refr          [NUM_NEURONS];
  logic [SW-1:0]        fifo          [NUM_NEURONS][D];

  logic [NUM_NEURONS-1:0] cmp, cmp_past, spike;
  logic signed [MW:0]     diff     [NUM_NEURONS];
  logic signed [MW-1:0]   soft_val [NUM_NEURONS];
  logic [PW-1:0]          pop;
  logic [CW:0]            count_sum;

  always_comb begin
    pop = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      cmp[n]      = membrane[n] >= threshold_i;
      cmp_past[n] = membrane_past[n] >= threshold_i;
      spike[n]    = cmp[n] && (refr[n] == '0);
      // Soft reset: subtract one bit wider, then clamp if the result left the signed range.
      diff[n] = {membrane[n][MW-1], membrane[n]} - {threshold_i[MW-1], threshold_i};
      if (diff[n][MW] != diff[n][MW-1]) soft_val[n] = diff[n][MW] ? M_MIN : M_MAX;
      else                              soft_val[n] = diff[n][MW-1:0];
      pop = pop + PW'(spike[n]);
    end
    count_sum = {1'b0, spike_count_o} + (CW+1)'(pop);
  end

  // Membranes, refractory counters, spike vector and spike counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        membrane[n]      <= '0;
        membrane_past[n] <= '0;
        refr[n]          <= '0;
      end
      post_spike_o  <= '0;
      spike_count_o <= '0;
    end else if (post_spiking_now_i) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (training_state_i) membrane_past[n] <= membrane[n];
        if (this_sample_done_i) begin
          membrane[n] <= '0;
          refr[n]     <= '0;
        end else if (spike[n]) begin
          membrane[n] <= (RESET_MODE == 1) ? soft_val[n] : '0;
          refr[n]     <= RW'(REFRACTORY_STEPS);
        end else begin
          membrane[n] <= membrane[n] >>> LEAK_SHIFT;
          if (refr[n] != '0) refr[n] <= refr[n] - RW'(1);
        end
      end
      post_spike_o  <= spike;
      spike_count_o <= this_sample_done_i ? '0
                     : (count_sum[CW] ? '1 : count_sum[CW-1:0]);
    end else if (membrane_update_valid_i) begin
      // Addresses beyond the last neuron match no index and are ignored.
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (membrane_update_addr_i == AW'(n)) membrane[n] <= membrane_update_i;
      end
    end
  end

  // Surrogate FIFOs: stage 0 is the head and stage D-1 is the visible tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int k = 0; k < D; k++) fifo[n][k] <= '0;
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (surrogate_read_finish_i) begin
          fifo[n][0] <= '0;
          for (int k = 1; k < D; k++) fifo[n][k] <= fifo[n][k-1];
        end else if (surrogate_compute_time_i && cmp_past[n]) begin
          fifo[n][0] <= surrogate_ref_i;
        end
      end
    end
  end

  always_comb begin
    membrane_o = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      surrogate_o[n*SW +: SW] = fifo[n][D-1];
      if (membrane_rd_addr_i == AW'(n)) membrane_o = membrane[n];
    end
  end

endmodule

// File: tb/tb_neuron_layer_array.sv
// tb_neuron_layer_array
//   Two layer instances share the same stimulus:
//     dut_a: 4 neurons, soft reset, 2 refractory steps, leak >>>1
//     dut_b: 6 neurons, hard reset, no refractory, leak >>>1
//   Expected values are pushed to exp_q when stimulus is driven. They are
//   popped and compared when the outputs are sampled, #1 after the clock edge.
module tb_neuron_layer_array;

  logic clk = 1'b0;
  logic reset_n;
  logic signed [16:0] thr, wdata;
  logic [2:0] waddr, raddr, sref;
  logic wvalid_a, wvalid_b, fire, train, done, compute, rfin;

  logic signed [16:0] mem_a, mem_b;
  logic [3:0]  spk_a;
  logic [5:0]  spk_b;
  logic [11:0] sur_a;
  logic [17:0] sur_b;
  logic [7:0]  cnt_a, cnt_b;

  logic [31:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int t2_pat[4] = '{1, 0, 0, 1};

  neuron_layer_array #(
    .NUM_NEURONS(4), .BIT_WIDTH_MEMBRANE(17), .BIT_WIDTH_SURROGATE(3),
    .DEPTH_SURROGATE_BOX(2), .LEAK_SHIFT(1), .RESET_MODE(1),
    .REFRACTORY_STEPS(2), .BIT_WIDTH_SPIKE_CNT(8)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .threshold_i(thr),
    .membrane_update_i(wdata), .membrane_update_addr_i(waddr[1:0]),
    .membrane_update_valid_i(wvalid_a), .post_spiking_now_i(fire),
    .training_state_i(train), .this_sample_done_i(done),
    .surrogate_compute_time_i(compute), .surrogate_ref_i(sref),
    .surrogate_read_finish_i(rfin), .membrane_rd_addr_i(raddr[1:0]),
    .membrane_o(mem_a), .post_spike_o(spk_a), .surrogate_o(sur_a),
    .spike_count_o(cnt_a)
  );

  neuron_layer_array #(
    .NUM_NEURONS(6), .BIT_WIDTH_MEMBRANE(17), .BIT_WIDTH_SURROGATE(3),
    .DEPTH_SURROGATE_BOX(2), .LEAK_SHIFT(1), .RESET_MODE(0),
    .REFRACTORY_STEPS(0), .BIT_WIDTH_SPIKE_CNT(8)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .threshold_i(thr),
    .membrane_update_i(wdata), .membrane_update_addr_i(waddr),
    .membrane_update_valid_i(wvalid_b), .post_spiking_now_i(fire),
    .training_state_i(train), .this_sample_done_i(done),
    .surrogate_compute_time_i(compute), .surrogate_ref_i(sref),
    .surrogate_read_finish_i(rfin), .membrane_rd_addr_i(raddr),
    .membrane_o(mem_b), .post_spike_o(spk_b), .surrogate_o(sur_b),
    .spike_count_o(cnt_b)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver and checking tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check_val({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    else                   check_val(tag, obs, exp_q.pop_front());
  endtask

  task automatic chk_mem(input bit use_b, input int a, input string tag);
    raddr = 3'(a);
    #1;
    if (use_b) pop_check(tag, mem_b);
    else       pop_check(tag, mem_a);
  endtask

  task automatic wr(input int a, input int v, input bit to_a, input bit to_b);
    waddr = 3'(a); wdata = 17'(v); wvalid_a = to_a; wvalid_b = to_b;
    tick();
    wvalid_a = 1'b0; wvalid_b = 1'b0;
  endtask

  task automatic fire_step(input bit d, input bit tr);
    fire = 1'b1; done = d; train = tr;
    tick();
    fire = 1'b0; done = 1'b0; train = 1'b0;
  endtask

  // Stimulus
  initial begin
    reset_n = 1'b0; thr = '0; wdata = '0; waddr = '0; raddr = '0; sref = '0;
    wvalid_a = 0; wvalid_b = 0; fire = 0; train = 0; done = 0; compute = 0; rfin = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    push(0); pop_check("rst_spk_a", spk_a);
    push(0); pop_check("rst_cnt_a", cnt_a);
    push(0); pop_check("rst_sur_a", sur_a);
    push(0); pop_check("rst_spk_b", spk_b);
    push(0); pop_check("rst_sur_b", sur_b);
    for (int i = 0; i < 4; i++) begin push(0); chk_mem(0, i, "rst_mem_a"); end
    reset_n = 1'b1;
    tick();

    // T1: single spike, soft vs hard reset, leak on the others
    thr = 64;
    wr(0, 10, 1, 1); wr(1, -7, 1, 1); wr(2, 100, 1, 1); wr(3, 63, 1, 1);
    push(4'b0100); push(6'b000100); push(1); push(1);
    fire_step(0, 0);
    pop_check("t1_spk_a", spk_a); pop_check("t1_spk_b", spk_b);
    pop_check("t1_cnt_a", cnt_a); pop_check("t1_cnt_b", cnt_b);
    push(5);  chk_mem(0, 0, "t1_mem_a0");
    push(-4); chk_mem(0, 1, "t1_mem_a1");
    push(36); chk_mem(0, 2, "t1_mem_a2");
    push(31); chk_mem(0, 3, "t1_mem_a3");
    push(0);  chk_mem(1, 2, "t1_mem_b2");
    push(31); chk_mem(1, 3, "t1_mem_b3");

    // Done step below threshold clears the sample
    thr = 50;
    push(0); push(0); push(0);
    fire_step(1, 0);
    pop_check("t2pre_spk_a", spk_a); pop_check("t2pre_cnt_a", cnt_a); pop_check("t2pre_cnt_b", cnt_b);

    // T2: refractory blocks two fire steps after a spike
    for (int i = 0; i < 4; i++) begin
      wr(0, 200, 1, 1);
      push(t2_pat[i]);
      fire_step(0, 0);
      pop_check("t2_spk_a", spk_a);
    end
    push(2); pop_check("t2_cnt_a", cnt_a);
    push(4); pop_check("t2_cnt_b", cnt_b);
    push(150); chk_mem(0, 0, "t2_mem_a0");

    // T3: write during fire step is dropped; out-of-range address ignored
    waddr = 3'd1; wdata = 17'd999; wvalid_a = 1; wvalid_b = 1; fire = 1;
    push(0);
    tick();
    wvalid_a = 0; wvalid_b = 0; fire = 0;
    pop_check("t3_spk_a", spk_a);
    push(0); chk_mem(0, 1, "t3_mem_a1");
    push(0); chk_mem(1, 1, "t3_mem_b1");
    wr(6, 77, 0, 1); wr(7, 88, 0, 1);
    for (int i = 0; i < 6; i++) begin push(0); chk_mem(1, i, "t3_mem_b_oor"); end
    wr(5, 33, 0, 1);
    push(33); chk_mem(1, 5, "t3_mem_b5");

    // T4: surrogate FIFO fill, shift and read_finish priority
    thr = 64;
    wr(0, 80, 1, 1);
    fire_step(0, 1);
    compute = 1; sref = 3'd5;
    tick();
    compute = 0;
    push(0); pop_check("t4_sur_a_head_only", sur_a);
    rfin = 1; tick(); rfin = 0;
    push(12'h005); pop_check("t4_sur_a_tail", sur_a);
    push(18'h5);   pop_check("t4_sur_b_tail", sur_b);
    rfin = 1; tick(); rfin = 0;
    push(0); pop_check("t4_sur_a_drained", sur_a);
    compute = 1; sref = 3'd5; tick();
    sref = 3'd3; rfin = 1; tick();
    compute = 0; rfin = 0;
    push(12'h005); pop_check("t4_sur_a_prio", sur_a);
    rfin = 1; tick(); rfin = 0;
    push(0); pop_check("t4_sur_a_prio_drop", sur_a);
    push(2); pop_check("t4_cnt_a", cnt_a);

    // T5: soft-reset saturation and negative leak
    thr = 17'h10000;
    wr(3, 65535, 1, 1);
    push(4'hF); push(6);
    fire_step(0, 0);
    pop_check("t5_spk_a", spk_a); pop_check("t5_cnt_a", cnt_a);
    push(65535); chk_mem(0, 3, "t5_mem_a3_sat");
    push(65535); chk_mem(0, 0, "t5_mem_a0_sat");
    thr = 0;
    wr(1, -7, 1, 1);
    push(0); push(6'b111101);
    fire_step(0, 0);
    pop_check("t5_spk_a_refr", spk_a); pop_check("t5_spk_b", spk_b);
    push(-4);    chk_mem(0, 1, "t5_mem_a1_leak");
    push(32767); chk_mem(0, 0, "t5_mem_a0_leak");

    // T6: done step clears membranes and counter, but still reports spikes
    push(0); push(0);
    fire_step(1, 0);
    pop_check("t6_spk_a_refr", spk_a); pop_check("t6_cnt_a", cnt_a);
    thr = 5;
    wr(0, 10, 1, 1);
    push(4'b0001); push(6'b000001); push(0); push(0);
    fire_step(1, 0);
    pop_check("t6_spk_a", spk_a); pop_check("t6_spk_b", spk_b);
    pop_check("t6_cnt_a", cnt_a); pop_check("t6_cnt_b", cnt_b);
    for (int i = 0; i < 4; i++) begin push(0); chk_mem(0, i, "t6_mem_a"); end

    // Spike counter saturation (dut_b) and refractory spacing (dut_a)
    thr = 17'h10000;
    for (int k = 1; k <= 43; k++) begin
      fire_step(0, 0);
      if (k == 42) begin
        push(252); pop_check("sat_cnt_b_42", cnt_b);
        push(56);  pop_check("sat_cnt_a_42", cnt_a);
      end
    end
    push(255);   pop_check("sat_cnt_b_43", cnt_b);
    push(60);    pop_check("sat_cnt_a_43", cnt_a);
    push(6'h3F); pop_check("sat_spk_b", spk_b);

    // Mid-run reset with live FIFOs and a pending write
    fire_step(0, 1);
    compute = 1; sref = 3'd6; tick(); compute = 0;
    rfin = 1; tick(); rfin = 0;
    push(12'hDB6);  pop_check("rr_sur_a_full", sur_a);
    push(18'h36DB6); pop_check("rr_sur_b_full", sur_b);
    #2;
    waddr = 3'd1; wdata = 17'd123; wvalid_a = 1; wvalid_b = 1;
    reset_n = 1'b0;
    #1;
    push(0); pop_check("rr_spk_a", spk_a);
    push(0); pop_check("rr_spk_b", spk_b);
    push(0); pop_check("rr_cnt_b", cnt_b);
    push(0); pop_check("rr_sur_a", sur_a);
    push(0); pop_check("rr_sur_b", sur_b);
    push(0); chk_mem(0, 0, "rr_mem_a0");
    tick();
    wvalid_a = 0; wvalid_b = 0;
    reset_n = 1'b1;
    tick();
    push(0); chk_mem(0, 1, "rr_mem_a1_nowrite");
    push(0); chk_mem(1, 1, "rr_mem_b1_nowrite");

    // Random write/readback
    for (int i = 0; i < 8; i++) begin
      int a, v;
      a = $urandom_range(0, 3);
      v = $urandom_range(0, 131071);
      wr(a, v, 1, 0);
      push(32'($signed(17'(v))));
      chk_mem(0, a, "rand_mem_a");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
